sdram_request_arbiter: RTL and testbench
========================================

Name: sdram_request_arbiter

Overview:
- Front end that feeds the SDRAM command controller.
- Accepts word requests from a write client (rasteriser/frame-buffer writer) and a read client (video scan-out), plus internally generated auto-refresh requests.
- Serialises them onto the controller's single command channel under a valid/ready handshake.
- Returns read data to the read client.
- Runs entirely in the dram_clk domain (166 MHz).

Parameters:
- REFRESH_INTERVAL, 1296: dram_clk cycles between refresh requests (7.8 us at 166 MHz).
- MAX_REFRESH_DEBT, 8: saturation limit of the pending-refresh counter.
- ADDR_WIDTH, 22: word address width, {bank[1:0], row[11:0], col[7:0]}.

Ports:
- dram_clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- ctl_init_done  in  1  controller finished the power-up sequence.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  16  write data.
- wr_mask  in  2  {udqm, ldqm}; 1 masks the byte.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted this cycle.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_data_valid  out  1  one-cycle strobe: rd_data is valid.
- rd_data  out  16  returned read word.
- ctl_valid  out  1  command present.
- ctl_ready  in  1  controller takes the command.
- ctl_cmd  out  2  00 write, 01 read, 10 refresh.
- ctl_addr  out  ADDR_WIDTH  command address (0 for refresh).
- ctl_data  out  16  write data.
- ctl_mask  out  2  write byte mask.
- ctl_rdata_valid  in  1  controller read-data strobe.
- ctl_rdata  in  16  controller read data.
- refresh_debt  out  4  current pending-refresh count (debug display).

Behaviour:
- Reset (async, reset_n low, any time):
  - All outputs 0; ctl_cmd = 00.
  - Refresh counter 0, debt 0, read_outstanding 0, last_grant = write.
  - Any in-flight command is dropped. No requests are accepted until ctl_init_done = 1.
- Refresh timer:
  - Counts only while ctl_init_done = 1.
  - On reaching REFRESH_INTERVAL-1 it wraps to 0 and increments debt.
  - Debt saturates at MAX_REFRESH_DEBT and does not wrap.
  - If the timer terminal count and a refresh command acceptance occur in the same cycle, debt is unchanged.
- States: IDLE, HOLD.
- IDLE:
  - When ctl_init_done = 1 and any request is eligible, grant one.
  - The grant loads the ctl_* registers, sets ctl_valid = 1 on the next edge, pulses the granted client's ready for exactly that cycle, and moves to HOLD.
- Priority:
  - Refresh (debt > 0) wins over everything.
  - Otherwise read and write alternate round-robin when both are valid: the one not in last_grant wins. A lone requester wins immediately.
  - Read is eligible only when read_outstanding = 0.
- HOLD:
  - ctl_valid and all ctl_* payload are held stable until ctl_ready = 1.
  - On the cycle ctl_ready = 1: drop ctl_valid, update last_grant (read/write only), decrement debt if refresh, set read_outstanding if read, return to IDLE.
  - No back-to-back issue: minimum 2 cycles per command.
- Client handshake:
  - Client holds valid and payload until it sees ready.
  - ready is never asserted without valid.
  - Payload is captured on the ready cycle; the client may change it the next cycle.
- Read return:
  - ctl_rdata_valid with read_outstanding = 1 → rd_data_valid = 1 and rd_data = ctl_rdata one cycle later (registered); read_outstanding clears in the same cycle.
  - ctl_rdata_valid with read_outstanding = 0 is ignored.
  - Writes and refreshes may issue while a read is outstanding.
- Init:
  - While ctl_init_done = 0, wr_ready = rd_ready = 0 and the timer is held at 0.
  - A drop of ctl_init_done mid-HOLD does not abort the held command.

Test Plan:
- Reset, ctl_init_done = 1, wr_valid with addr 0x000123 / data 0x1234 / mask 00, ctl_ready tied 1 → wr_ready pulses once; next cycle ctl_valid = 1, cmd = 00, addr 0x000123, data 0x1234; ctl_valid low one cycle later.
- wr_valid and rd_valid held together for 4 grants, ctl_ready = 1, rdata returned 3 cycles after each read → grant order read, write, read, write.
- ctl_ready held 0 for 5 cycles during HOLD → ctl_* stable all 5 cycles; no second ready pulse to either client.
- No traffic for 3×REFRESH_INTERVAL with ctl_ready = 0, then ctl_ready = 1 → refresh_debt reads 3; three refresh commands issue before a pending write; debt counts 3→0.
- No traffic for 10×REFRESH_INTERVAL → debt saturates at 8. Read issued, ctl_rdata_valid with 0xBEEF → rd_data_valid one cycle later with rd_data = 0xBEEF. A second rd_valid is not granted until the return.
- reset_n pulsed low while in HOLD with cmd = read → all outputs 0 immediately; a subsequent ctl_rdata_valid produces no rd_data_valid.

Source files
------------

// File: rtl/sdram_request_arbiter.sv
// SDRAM request arbiter: serialises write-client, read-client and auto-refresh
// requests onto the single controller command channel and returns read data.
module sdram_request_arbiter #(
  parameter int unsigned REFRESH_INTERVAL = 1296,
  parameter int unsigned MAX_REFRESH_DEBT = 8,
  parameter int unsigned ADDR_WIDTH       = 22
) (
  input  logic                  dram_clk,
  input  logic                  reset_n,
  input  logic                  ctl_init_done,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [15:0]           wr_data,
  input  logic [1:0]            wr_mask,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_data_valid,
  output logic [15:0]           rd_data,
  output logic                  ctl_valid,
  input  logic                  ctl_ready,
  output logic [1:0]            ctl_cmd,
  output logic [ADDR_WIDTH-1:0] ctl_addr,
  output logic [15:0]           ctl_data,
  output logic [1:0]            ctl_mask,
  input  logic                  ctl_rdata_valid,
  input  logic [15:0]           ctl_rdata,
  output logic [3:0]            refresh_debt
);

  localparam int unsigned TimerW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TimerW-1:0] TimerTerm = TimerW'(REFRESH_INTERVAL - 1);
  localparam logic [3:0] MaxDebt = 4'(MAX_REFRESH_DEBT);

  localparam logic [1:0] CmdWrite   = 2'b00;
  localparam logic [1:0] CmdRead    = 2'b01;
  localparam logic [1:0] CmdRefresh = 2'b10;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  logic [0:0]            state_q;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [3:0]            debt_q, debt_d;
  logic                  rd_out_q;
  logic                  last_grant_q;  // 0: write, 1: read
  logic                  run_q;         // low only while reset is held or just released
  logic                  ctl_valid_q;
  logic [1:0]            ctl_cmd_q;
  logic [ADDR_WIDTH-1:0] ctl_addr_q;
  logic [15:0]           ctl_data_q;
  logic [1:0]            ctl_mask_q;
  logic                  rd_data_valid_q;
  logic [15:0]           rd_data_q;

  logic tick;
  logic ref_accept;
  logic rd_eligible;
  logic grant_ref, grant_rd, grant_wr;

  assign tick       = ctl_init_done && (timer_q == TimerTerm);
  assign ref_accept = (state_q == StHold) && ctl_ready && (ctl_cmd_q == CmdRefresh);

  // Refresh timer and refresh-debt next state.
  always_comb begin
    timer_d = timer_q;
    debt_d  = debt_q;
    if (!ctl_init_done) begin
      timer_d = '0;
    end else if (timer_q == TimerTerm) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
    // A tick and a refresh acceptance in the same cycle cancel out.
    if (tick && !ref_accept) begin
      if (debt_q != MaxDebt) begin
        debt_d = debt_q + 4'd1;
      end
    end else if (ref_accept && !tick) begin
      debt_d = debt_q - 4'd1;
    end
  end

  // Grant selection in IDLE: refresh first, then read/write round-robin.
  always_comb begin
    grant_ref   = 1'b0;
    grant_rd    = 1'b0;
    grant_wr    = 1'b0;
    rd_eligible = rd_valid && !rd_out_q;
    if (run_q && (state_q == StIdle) && ctl_init_done) begin
      if (debt_q != 4'd0) begin
        grant_ref = 1'b1;
      end else if (rd_eligible && wr_valid) begin
        if (last_grant_q) begin
          grant_wr = 1'b1;
        end else begin
          grant_rd = 1'b1;
        end
      end else if (rd_eligible) begin
        grant_rd = 1'b1;
      end else if (wr_valid) begin
        grant_wr = 1'b1;
      end
    end
  end

  assign wr_ready = grant_wr;
  assign rd_ready = grant_rd;

  // Timer, debt and read-outstanding state.
  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q  <= '0;
      debt_q   <= '0;
      rd_out_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      timer_q <= timer_d;
      debt_q  <= debt_d;
      run_q   <= 1'b1;
      if ((state_q == StHold) && ctl_ready && (ctl_cmd_q == CmdRead)) begin
        rd_out_q <= 1'b1;
      end else if (ctl_rdata_valid && rd_out_q) begin
        rd_out_q <= 1'b0;
      end
    end
  end

  // Command FSM: load the command register on a grant, hold it until taken.
  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b0;
      ctl_valid_q  <= 1'b0;
      ctl_cmd_q    <= CmdWrite;
      ctl_addr_q   <= '0;
      ctl_data_q   <= '0;
      ctl_mask_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_ref || grant_rd || grant_wr) begin
            state_q     <= StHold;
            ctl_valid_q <= 1'b1;
            if (grant_ref) begin
              ctl_cmd_q  <= CmdRefresh;
              ctl_addr_q <= '0;
              ctl_data_q <= '0;
              ctl_mask_q <= '0;
            end else if (grant_rd) begin
              ctl_cmd_q  <= CmdRead;
              ctl_addr_q <= rd_addr;
              ctl_data_q <= '0;
              ctl_mask_q <= '0;
            end else begin
              ctl_cmd_q  <= CmdWrite;
              ctl_addr_q <= wr_addr;
              ctl_data_q <= wr_data;
              ctl_mask_q <= wr_mask;
            end
          end
        end
        StHold: begin
          if (ctl_ready) begin
            state_q     <= StIdle;
            ctl_valid_q <= 1'b0;
            if (ctl_cmd_q != CmdRefresh) begin
              last_grant_q <= (ctl_cmd_q == CmdRead);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Registered read-data return; strobes with no read outstanding are dropped.
  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_valid_q <= 1'b0;
      rd_data_q       <= '0;
    end else begin
      rd_data_valid_q <= ctl_rdata_valid && rd_out_q;
      if (ctl_rdata_valid && rd_out_q) begin
        rd_data_q <= ctl_rdata;
      end
    end
  end

  assign ctl_valid     = ctl_valid_q;
  assign ctl_cmd       = ctl_cmd_q;
  assign ctl_addr      = ctl_addr_q;
  assign ctl_data      = ctl_data_q;
  assign ctl_mask      = ctl_mask_q;
  assign rd_data_valid = rd_data_valid_q;
  assign rd_data       = rd_data_q;
  assign refresh_debt  = debt_q;

endmodule

// File: tb/tb_sdram_request_arbiter.sv
// Scoreboard bench for sdram_request_arbiter: expected commands and read
// returns are queued by the stimulus; a negedge monitor pops and compares.
module tb_sdram_request_arbiter;

  localparam int unsigned RI = 50;
  localparam int unsigned AW = 22;

  logic          dram_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ctl_init_done = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic [1:0]    wr_mask = '0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_data_valid;
  logic [15:0]   rd_data;
  logic          ctl_valid;
  logic          ctl_ready = 1'b0;
  logic [1:0]    ctl_cmd;
  logic [AW-1:0] ctl_addr;
  logic [15:0]   ctl_data;
  logic [1:0]    ctl_mask;
  logic          ctl_rdata_valid = 1'b0;
  logic [15:0]   ctl_rdata = '0;
  logic [3:0]    refresh_debt;

  sdram_request_arbiter #(
    .REFRESH_INTERVAL(RI),
    .MAX_REFRESH_DEBT(8),
    .ADDR_WIDTH(AW)
  ) dut (
    .dram_clk(dram_clk), .reset_n(reset_n), .ctl_init_done(ctl_init_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .ctl_valid(ctl_valid),
    .ctl_ready(ctl_ready), .ctl_cmd(ctl_cmd), .ctl_addr(ctl_addr), .ctl_data(ctl_data),
    .ctl_mask(ctl_mask), .ctl_rdata_valid(ctl_rdata_valid), .ctl_rdata(ctl_rdata),
    .refresh_debt(refresh_debt)
  );

  always #5 dram_clk = ~dram_clk;

  typedef struct {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    mask;
    int            debt;
  } cmd_t;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } rdr_t;

  cmd_t exp_cmd[$];
  rdr_t exp_rd[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  bit wr_seen = 1'b0;
  bit rd_seen = 1'b0;
  int ret_cnt = 0;
  bit auto_ret = 1'b0;
  logic [15:0] ret_val = 16'hA000;
  bit hold_prev = 1'b0;
  logic [41:0] snap = '0;
  cmd_t mon_e;
  rdr_t mon_r;

  logic [AW-1:0] wa [0:3];
  logic [15:0]   wd [0:3];
  logic [1:0]    wm [0:3];
  logic [AW-1:0] ra [0:3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_w(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
    exp_cmd.push_back('{cmd: 2'b00, addr: a, data: d, mask: m, debt: 0});
  endtask

  task automatic exp_r(input logic [AW-1:0] a);
    exp_cmd.push_back('{cmd: 2'b01, addr: a, data: 16'h0, mask: 2'b00, debt: 0});
  endtask

  task automatic exp_f(input int d);
    exp_cmd.push_back('{cmd: 2'b10, addr: '0, data: 16'h0, mask: 2'b00, debt: d});
  endtask

  task automatic drive_rdata(input logic [15:0] d);
    ctl_rdata       = d;
    ctl_rdata_valid = 1'b1;
    exp_rd.push_back('{data: d, cyc: cyc + 1});
  endtask

  always @(posedge dram_clk) cyc++;

  // Monitor: client ready pulses, command acceptances, hold stability, read returns.
  always @(negedge dram_clk) begin
    wr_seen = wr_ready;
    rd_seen = rd_ready;
    if (wr_ready) wr_pulses++;
    if (rd_ready) rd_pulses++;
    if (!reset_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && ctl_valid)
        check("hold_stable", {ctl_cmd, ctl_addr, ctl_data, ctl_mask}, snap);
      if (ctl_valid && ctl_ready) begin
        if (exp_cmd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got cmd %b addr %h, expected no command", ctl_cmd,
                   ctl_addr);
        end else begin
          mon_e = exp_cmd.pop_front();
          check("ctl_cmd", ctl_cmd, mon_e.cmd);
          check("ctl_addr", ctl_addr, mon_e.addr);
          if (mon_e.cmd == 2'b00) begin
            check("ctl_data", ctl_data, mon_e.data);
            check("ctl_mask", ctl_mask, mon_e.mask);
          end
          if (mon_e.cmd == 2'b10) check("debt_at_refresh", refresh_debt, mon_e.debt);
          if (mon_e.cmd == 2'b01 && auto_ret) ret_cnt = 2;
        end
      end
      hold_prev = ctl_valid && !ctl_ready;
      snap = {ctl_cmd, ctl_addr, ctl_data, ctl_mask};
      if (rd_data_valid) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rdata: got rd_data %h, expected no strobe", rd_data);
        end else begin
          mon_r = exp_rd.pop_front();
          check("rd_data", rd_data, mon_r.data);
          check("rd_data_cycle", mon_r.cyc, cyc);
        end
      end
    end
  end

  // One clock: advance to just after the rising edge, then run the read-return model.
  task automatic step();
    @(posedge dram_clk);
    #1;
    ctl_rdata_valid = 1'b0;
    if (ret_cnt > 0) begin
      ret_cnt--;
      if (ret_cnt == 0) begin
        drive_rdata(ret_val);
        ret_val++;
      end
    end
  endtask

  task automatic wait_ready(input bit rd, input string name, input int bound);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(rd ? rd_seen : wr_seen) && n < bound);
    checks++;
    if (!(rd ? rd_seen : wr_seen)) begin
      errors++;
      $display("FAIL %s: ready not seen within %0d cycles", name, bound);
    end
  endtask

  task automatic apply_reset();
    reset_n         = 1'b0;
    ctl_init_done   = 1'b0;
    wr_valid        = 1'b0;
    rd_valid        = 1'b0;
    ctl_ready       = 1'b0;
    ctl_rdata_valid = 1'b0;
    auto_ret        = 1'b0;
    ret_cnt         = 0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    int wi, ri, n, p_w, p_r;
    wa[0] = 22'h000123; wa[1] = 22'h0ABCDE; wa[2] = 22'h155555; wa[3] = 22'h3FFFFF;
    wd[0] = 16'h1234;   wd[1] = 16'hCAFE;   wd[2] = 16'h0F0F;   wd[3] = 16'hA5A5;
    wm[0] = 2'b00;      wm[1] = 2'b01;      wm[2] = 2'b10;      wm[3] = 2'b11;
    ra[0] = 22'h001040; ra[1] = 22'h2F00AA; ra[2] = 22'h00FF00; ra[3] = 22'h1C0301;

    // Reset state and init gating.
    apply_reset();
    check("reset_ctl", {ctl_valid, ctl_cmd, ctl_addr, ctl_data, ctl_mask}, '0);
    check("reset_rd", {rd_data_valid, rd_data}, '0);
    check("reset_debt", refresh_debt, 4'd0);
    wr_valid = 1'b1; wr_addr = wa[0]; wr_data = wd[0]; wr_mask = wm[0];
    p_w = wr_pulses;
    repeat (RI + 10) step();
    check("no_grant_before_init", wr_pulses, p_w);
    check("timer_held_before_init", refresh_debt, 4'd0);

    // Single write with ctl_ready tied high.
    ctl_ready = 1'b1;
    exp_w(wa[0], wd[0], wm[0]);
    ctl_init_done = 1'b1;
    wait_ready(1'b0, "t1_wr_ready", 5);
    wr_valid = 1'b0;
    check("t1_ctl_valid_high", ctl_valid, 1'b1);
    step();
    check("t1_ctl_valid_low", ctl_valid, 1'b0);
    step();
    check("t1_wr_pulses", wr_pulses - p_w, 1);

    // Both clients valid: round-robin read, write, read, write.
    apply_reset();
    ctl_init_done = 1'b1; ctl_ready = 1'b1; auto_ret = 1'b1;
    exp_r(ra[0]); exp_w(wa[1], wd[1], wm[1]); exp_r(ra[1]); exp_w(wa[2], wd[2], wm[2]);
    wi = 0; ri = 0; n = 0;
    wr_valid = 1'b1; wr_addr = wa[1]; wr_data = wd[1]; wr_mask = wm[1];
    rd_valid = 1'b1; rd_addr = ra[0];
    while ((wi < 2 || ri < 2) && n < 40) begin
      step();
      n++;
      if (wr_seen) begin
        wi++;
        if (wi == 2) wr_valid = 1'b0;
        else begin wr_addr = wa[2]; wr_data = wd[2]; wr_mask = wm[2]; end
      end
      if (rd_seen) begin
        ri++;
        if (ri == 2) rd_valid = 1'b0;
        else rd_addr = ra[1];
      end
    end
    check("t2_all_granted", {wi[1:0], ri[1:0]}, {2'd2, 2'd2});
    repeat (6) step();

    // Command held stable through 5 cycles of ctl_ready low.
    apply_reset();
    ctl_init_done = 1'b1; ctl_ready = 1'b0; auto_ret = 1'b1;
    exp_w(wa[3], wd[3], wm[3]); exp_r(ra[2]);
    wr_valid = 1'b1; wr_addr = wa[3]; wr_data = wd[3]; wr_mask = wm[3];
    wait_ready(1'b0, "t3_wr_ready", 5);
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_valid = 1'b1; rd_addr = ra[2];
    p_w = wr_pulses; p_r = rd_pulses;
    repeat (5) step();
    check("t3_held_valid", {ctl_valid, ctl_cmd}, {1'b1, 2'b00});
    check("t3_no_wr_pulse", wr_pulses, p_w);
    check("t3_no_rd_pulse", rd_pulses, p_r);
    ctl_ready = 1'b1;
    wait_ready(1'b1, "t3_rd_ready", 10);
    rd_valid = 1'b0;
    repeat (6) step();

    // Refresh debt accumulates to 3, then drains ahead of a pending write.
    apply_reset();
    ctl_init_done = 1'b1; ctl_ready = 1'b0;
    repeat (3 * RI + 5) step();
    check("t4_debt3", refresh_debt, 4'd3);
    check("t4_refresh_held", {ctl_valid, ctl_cmd}, {1'b1, 2'b10});
    exp_f(3); exp_f(2); exp_f(1); exp_w(wa[1], wd[1], wm[1]);
    wr_valid = 1'b1; wr_addr = wa[1]; wr_data = wd[1]; wr_mask = wm[1];
    ctl_ready = 1'b1;
    wait_ready(1'b0, "t4_wr_ready", 30);
    wr_valid = 1'b0;
    repeat (3) step();
    check("t4_debt0", refresh_debt, 4'd0);

    // Debt saturates at 8; read return and read-outstanding blocking.
    apply_reset();
    ctl_init_done = 1'b1; ctl_ready = 1'b0;
    repeat (10 * RI + 5) step();
    check("t5_debt_sat", refresh_debt, 4'd8);
    for (int d = 8; d >= 1; d--) exp_f(d);
    exp_r(ra[3]);
    rd_valid = 1'b1; rd_addr = ra[3];
    ctl_ready = 1'b1;
    wait_ready(1'b1, "t5_rd_ready", 40);
    rd_addr = ra[0];
    p_r = rd_pulses;
    repeat (6) step();
    check("t5_rd_blocked", rd_pulses, p_r);
    exp_r(ra[0]);
    drive_rdata(16'hBEEF);
    wait_ready(1'b1, "t5_rd2_ready", 10);
    rd_valid = 1'b0;
    check("t5_rd2_single_pulse", rd_pulses - p_r, 1);
    repeat (3) step();

    // Reset during a held read drops everything; later strobe is ignored.
    apply_reset();
    ctl_init_done = 1'b1; ctl_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = ra[1];
    wait_ready(1'b1, "t6_rd_ready", 5);
    rd_valid = 1'b0;
    check("t6_read_held", {ctl_valid, ctl_cmd}, {1'b1, 2'b01});
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_ctl", {ctl_valid, ctl_cmd, ctl_addr, ctl_data, ctl_mask}, '0);
    check("t6_async_misc", {wr_ready, rd_ready, rd_data_valid, rd_data, refresh_debt}, '0);
    step();
    step();
    reset_n = 1'b1;
    step();
    ctl_rdata = 16'h5555;
    ctl_rdata_valid = 1'b1;
    step();
    step();
    check("t6_no_rdata", {rd_data_valid, rd_data}, '0);

    check("cmd_queue_empty", exp_cmd.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
